apb_led_pwm_regs: RTL and testbench

- Parametrised APB slave register block driving NUM_CH RGB LED channels.
- Adds per-channel modes (off / static / blink / PWM dimming), a shared prescaler, byte strobes, address-range error reporting and a read-only ID register.
- Sits on the peripheral bus beside the other APB slaves; LED outputs go straight to board pins.

---
 rtl/led_pwm_pkg.sv | 44 ++++
 rtl/led_pwm_channel.sv | 68 ++++++
 rtl/apb_led_pwm_regs.sv | 157 +++++++++++++++
 tb/tb_apb_led_pwm_regs.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_pwm_pkg.sv
// Shared constants, mode encoding and field layout for the APB LED PWM register block.
`timescale 1ns/1ps
package led_pwm_pkg;

  localparam int unsigned APB_DW    = 32;
  localparam int unsigned HALF_W    = 8;
  localparam int unsigned CH_STRIDE = 8;

  localparam logic [APB_DW-1:0] LED_ID = 32'h4C45_4402;

  localparam logic [7:0] OFF_ID       = 8'h00;
  localparam logic [7:0] OFF_PRESCALE = 8'h04;
  localparam logic [7:0] OFF_CTRL0    = 8'h10;
  localparam logic [7:0] OFF_CFG0     = 8'h14;

  localparam int unsigned CTRL_MASK_LSB = 0;
  localparam int unsigned CTRL_MODE_LSB = 4;
  localparam int unsigned CFG_DUTY_LSB  = 0;
  localparam int unsigned CFG_HALF_LSB  = 16;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_STATIC = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_PWM    = 2'b11
  } mode_e;

  typedef struct packed {
    mode_e      mode;
    logic [2:0] mask;
  } ctrl_t;

  // Byte-lane merge of a write into the current register image.
  function automatic logic [APB_DW-1:0] strb_merge(input logic [APB_DW-1:0] old_v,
                                                   input logic [APB_DW-1:0] new_v,
                                                   input logic [3:0]        strb);
    logic [APB_DW-1:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One RGB channel: blink counter/phase, mode select and the registered colour output.
`timescale 1ns/1ps
module led_pwm_channel
  import led_pwm_pkg::*;
#(
  parameter int unsigned PWM_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  mode_e             mode_i,
  input  logic [2:0]        mask_i,
  input  logic [PWM_W-1:0]  duty_i,
  input  logic [HALF_W-1:0] half_i,
  input  logic [PWM_W-1:0]  pwm_cnt_i,
  input  logic              frame_end_i,
  input  logic              mode_chg_i,
  output logic [2:0]        led_o
);

  logic [HALF_W-1:0] blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;
  logic [2:0]        led_q, led_d;
  logic              on_c;

  // A mode change restarts the blink sequence from phase 0.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (mode_chg_i) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (frame_end_i) begin
      if (blink_cnt_q == half_i) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = HALF_W'(blink_cnt_q + 1'b1);
      end
    end
  end

  always_comb begin
    on_c = 1'b0;
    case (mode_i)
      MODE_OFF:    on_c = 1'b0;
      MODE_STATIC: on_c = 1'b1;
      MODE_BLINK:  on_c = phase_q;
      MODE_PWM:    on_c = (duty_i > pwm_cnt_i);
      default:     on_c = 1'b0;
    endcase
    led_d = on_c ? mask_i : 3'b000;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      led_q       <= 3'b000;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      led_q       <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/apb_led_pwm_regs.sv
// APB slave holding prescaler and per-channel LED registers; drives NUM_CH RGB outputs.
`timescale 1ns/1ps
module apb_led_pwm_regs
  import led_pwm_pkg::*;
#(
  parameter int unsigned    AW        = 16,
  parameter int unsigned    DW        = 32,
  parameter logic [AW-1:0]  BASE_ADDR = 16'h0200,
  parameter int unsigned    NUM_CH    = 2,
  parameter int unsigned    PWM_W     = 8,
  parameter int unsigned    PRESC_W   = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [AW-1:0]       PADDR,
  input  logic [DW-1:0]       PWDATA,
  input  logic [3:0]          PSTRB,
  output logic [DW-1:0]       PRDATA,
  output logic                PREADY,
  output logic                PSLVERR,
  output logic [3*NUM_CH-1:0] led_rgb
);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  ctrl_t              ctrl_q [NUM_CH];
  ctrl_t              ctrl_d [NUM_CH];
  logic [PWM_W-1:0]   duty_q [NUM_CH];
  logic [PWM_W-1:0]   duty_d [NUM_CH];
  logic [HALF_W-1:0]  half_q [NUM_CH];
  logic [HALF_W-1:0]  half_d [NUM_CH];

  logic [7:0]        off_c;
  logic              base_hit_c, access_c, addr_err_c, wr_en_c;
  logic              sel_id_c, sel_presc_c, mapped_c;
  logic [NUM_CH-1:0] sel_ctrl_c, sel_cfg_c, mode_chg_c;
  logic [DW-1:0]     rd_img_c, wmerge_c;
  logic              tick_c, frame_end_c;
  logic              unused_wmerge_c;

  assign off_c       = PADDR[7:0];
  assign base_hit_c  = (PADDR[AW-1:8] == BASE_ADDR[AW-1:8]);
  assign access_c    = PSEL & base_hit_c;
  assign sel_id_c    = (off_c == OFF_ID);
  assign sel_presc_c = (off_c == OFF_PRESCALE);

  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      sel_ctrl_c[ch] = (off_c == 8'(OFF_CTRL0 + CH_STRIDE * ch));
      sel_cfg_c[ch]  = (off_c == 8'(OFF_CFG0 + CH_STRIDE * ch));
    end
  end

  // Gap offsets, anything past the last channel and unaligned addresses are all unmapped.
  assign mapped_c   = sel_id_c | sel_presc_c | (|sel_ctrl_c) | (|sel_cfg_c);
  assign addr_err_c = (off_c[1:0] != 2'b00) | ~mapped_c | (PWRITE & sel_id_c);
  assign wr_en_c    = access_c & PENABLE & PWRITE & ~addr_err_c;

  // Image of the addressed register, used both for reads and as the strobe-merge base.
  always_comb begin
    rd_img_c = '0;
    if (sel_id_c)    rd_img_c = LED_ID;
    if (sel_presc_c) rd_img_c = DW'(presc_q);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (sel_ctrl_c[ch]) begin
        rd_img_c = DW'({ctrl_q[ch].mode, 1'b0, ctrl_q[ch].mask});
      end
      if (sel_cfg_c[ch]) begin
        rd_img_c = (DW'(half_q[ch]) << CFG_HALF_LSB) | (DW'(duty_q[ch]) << CFG_DUTY_LSB);
      end
    end
  end

  assign wmerge_c        = strb_merge(rd_img_c, PWDATA, PSTRB);
  assign unused_wmerge_c = ^wmerge_c;

  assign PRDATA  = (access_c & ~PWRITE & ~addr_err_c) ? rd_img_c : '0;
  assign PSLVERR = access_c & PENABLE & addr_err_c;
  assign PREADY  = 1'b1;

  always_comb begin
    presc_d    = presc_q;
    mode_chg_c = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      ctrl_d[ch] = ctrl_q[ch];
      duty_d[ch] = duty_q[ch];
      half_d[ch] = half_q[ch];
    end
    if (wr_en_c && sel_presc_c) presc_d = wmerge_c[PRESC_W-1:0];
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (wr_en_c && sel_ctrl_c[ch]) begin
        ctrl_d[ch].mask = wmerge_c[CTRL_MASK_LSB +: 3];
        ctrl_d[ch].mode = mode_e'(wmerge_c[CTRL_MODE_LSB +: 2]);
        mode_chg_c[ch]  = (ctrl_d[ch].mode != ctrl_q[ch].mode);
      end
      if (wr_en_c && sel_cfg_c[ch]) begin
        duty_d[ch] = wmerge_c[CFG_DUTY_LSB +: PWM_W];
        half_d[ch] = wmerge_c[CFG_HALF_LSB +: HALF_W];
      end
    end
  end

  // Prescaler restarts on any PRESCALE write so the new period takes effect cleanly.
  assign tick_c      = (presc_cnt_q == presc_q);
  assign frame_end_c = tick_c & (pwm_cnt_q == {PWM_W{1'b1}});

  always_comb begin
    if (wr_en_c && sel_presc_c) presc_cnt_d = '0;
    else if (tick_c)            presc_cnt_d = '0;
    else                        presc_cnt_d = PRESC_W'(presc_cnt_q + 1'b1);
    pwm_cnt_d = tick_c ? PWM_W'(pwm_cnt_q + 1'b1) : pwm_cnt_q;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      presc_q     <= '0;
      presc_cnt_q <= '0;
      pwm_cnt_q   <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        ctrl_q[ch] <= '{mode: MODE_OFF, mask: 3'b000};
        duty_q[ch] <= '0;
        half_q[ch] <= '0;
      end
    end else begin
      presc_q     <= presc_d;
      presc_cnt_q <= presc_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        ctrl_q[ch] <= ctrl_d[ch];
        duty_q[ch] <= duty_d[ch];
        half_q[ch] <= half_d[ch];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    led_pwm_channel #(
      .PWM_W (PWM_W)
    ) u_ch (
      .clk_i       (PCLK),
      .rst_ni      (PRESETn),
      .mode_i      (ctrl_q[g].mode),
      .mask_i      (ctrl_q[g].mask),
      .duty_i      (duty_q[g]),
      .half_i      (half_q[g]),
      .pwm_cnt_i   (pwm_cnt_q),
      .frame_end_i (frame_end_c),
      .mode_chg_i  (mode_chg_c[g]),
      .led_o       (led_rgb[3*g +: 3])
    );
  end

endmodule

// File: tb/tb_apb_led_pwm_regs.sv
// Directed bench for apb_led_pwm_regs: register-map vector table plus PWM, blink and reset sequences.
`timescale 1ns/1ps
module tb_apb_led_pwm_regs;

  localparam int unsigned AW     = 16;
  localparam int unsigned NUM_CH = 2;
  localparam logic [31:0] ID_VAL = 32'h4C45_4402;

  logic                PCLK = 1'b0;
  logic                PRESETn = 1'b0;
  logic                PSEL = 1'b0;
  logic                PENABLE = 1'b0;
  logic                PWRITE = 1'b0;
  logic [AW-1:0]       PADDR = '0;
  logic [31:0]         PWDATA = '0;
  logic [3:0]          PSTRB = '0;
  logic [31:0]         PRDATA;
  logic                PREADY;
  logic                PSLVERR;
  logic [3*NUM_CH-1:0] led_rgb;

  apb_led_pwm_regs #(
    .AW(AW), .DW(32), .BASE_ADDR(16'h0200), .NUM_CH(NUM_CH), .PWM_W(8), .PRESC_W(16)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .led_rgb(led_rgb)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_d;
    bit          exp_e;
    string       nm;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic addv(input bit wr, input logic [15:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [31:0] exp_d, input bit exp_e,
                      input string nm);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.strb = strb;
    v.exp_d = exp_d; v.exp_e = exp_e; v.nm = nm;
    vt.push_back(v);
  endtask

  task automatic apb(input bit wr, input logic [15:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, output logic [31:0] rdata, output logic err);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data; PSTRB = strb;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    rdata = PRDATA;
    err   = PSLVERR;
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr32(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] rd;
    logic        e;
    apb(1'b1, addr, data, strb, rd, e);
  endtask

  task automatic rd_chk(input string nm, input logic [15:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic        e;
    apb(1'b0, addr, 32'h0, 4'h0, rd, e);
    chk({nm, "_data"}, rd, exp);
    chk({nm, "_err"}, {31'b0, e}, 32'd0);
  endtask

  task automatic wait_ch1_change(output int t, output bit ok);
    logic [2:0] prev;
    prev = led_rgb[5:3];
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge PCLK);
      if (led_rgb[5:3] !== prev) begin
        t  = cyc;
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        e;
    int          n_on, n_bad, t0, t1, t2;
    bit          ok;

    // Reset state
    repeat (3) @(negedge PCLK);
    chk("rst_led", 32'(led_rgb), 32'd0);
    chk("rst_prdata", PRDATA, 32'd0);
    chk("rst_pslverr", {31'b0, PSLVERR}, 32'd0);
    chk("pready", {31'b0, PREADY}, 32'd1);
    PRESETn = 1'b1;
    repeat (2) @(negedge PCLK);

    addv(0, 16'h0200, 0, 4'h0, ID_VAL,        0, "rd_id");
    addv(0, 16'h0204, 0, 4'h0, 32'h0,         0, "rd_presc_rst");
    addv(0, 16'h0210, 0, 4'h0, 32'h0,         0, "rd_ctrl0_rst");
    addv(0, 16'h0214, 0, 4'h0, 32'h0,         0, "rd_cfg0_rst");
    addv(1, 16'h0200, 32'hFFFF_FFFF, 4'hF, 0, 1, "wr_id");
    addv(0, 16'h0200, 0, 4'h0, ID_VAL,        0, "rd_id_after_wr");
    addv(0, 16'h0230, 0, 4'h0, 32'h0,         1, "rd_beyond");
    addv(0, 16'h0220, 0, 4'h0, 32'h0,         1, "rd_past_last_ch");
    addv(1, 16'h0212, 32'h0000_0035, 4'hF, 0, 1, "wr_unaligned");
    addv(0, 16'h0216, 0, 4'h0, 32'h0,         1, "rd_unaligned");
    addv(0, 16'h0210, 0, 4'h0, 32'h0,         0, "rd_ctrl0_after_unal");
    addv(1, 16'h0214, 32'hAABB_CCDD, 4'h1, 0, 0, "wr_cfg0_lane0");
    addv(0, 16'h0214, 0, 4'h0, 32'h0000_00DD, 0, "rd_cfg0_lane0");
    addv(1, 16'h0214, 32'hAABB_CCDD, 4'h4, 0, 0, "wr_cfg0_lane2");
    addv(0, 16'h0214, 0, 4'h0, 32'h00BB_00DD, 0, "rd_cfg0_lane2");
    addv(1, 16'h0204, 32'h1234_5678, 4'h3, 0, 0, "wr_presc");
    addv(0, 16'h0204, 0, 4'h0, 32'h0000_5678, 0, "rd_presc");
    addv(1, 16'h0304, 32'hFFFF_FFFF, 4'hF, 0, 0, "wr_base_miss");
    addv(0, 16'h0204, 0, 4'h0, 32'h0000_5678, 0, "rd_presc_after_miss");
    addv(0, 16'h0300, 0, 4'h0, 32'h0,         0, "rd_base_miss");
    addv(1, 16'h021C, 32'hFFFF_FFFF, 4'hF, 0, 0, "wr_cfg1_all");
    addv(0, 16'h021C, 0, 4'h0, 32'h00FF_00FF, 0, "rd_cfg1_all");
    addv(1, 16'h0218, 32'hFFFF_FFFF, 4'hF, 0, 0, "wr_ctrl1_all");
    addv(0, 16'h0218, 0, 4'h0, 32'h0000_0037, 0, "rd_ctrl1_all");
    addv(1, 16'h0218, 32'h0, 4'hF, 0, 0,         "clr_ctrl1");
    addv(1, 16'h021C, 32'h0, 4'hF, 0, 0,         "clr_cfg1");
    addv(1, 16'h0214, 32'h0, 4'hF, 0, 0,         "clr_cfg0");
    addv(1, 16'h0204, 32'h0, 4'hF, 0, 0,         "clr_presc");
    addv(0, 16'h0204, 0, 4'h0, 32'h0,         0, "rd_presc_clr");

    foreach (vt[i]) begin
      apb(vt[i].wr, vt[i].addr, vt[i].data, vt[i].strb, rd, e);
      chk({vt[i].nm, "_err"}, {31'b0, e}, {31'b0, vt[i].exp_e});
      if (!vt[i].wr) chk({vt[i].nm, "_data"}, rd, vt[i].exp_d);
    end

    // PWM dimming on channel 0: duty 0x40 -> 64 of 256 cycles lit
    wr32(16'h0214, 32'h0000_0040, 4'h1);
    wr32(16'h0210, 32'h0000_0035, 4'h1);
    repeat (3) @(negedge PCLK);
    n_on = 0; n_bad = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge PCLK);
      if (led_rgb[2:0] === 3'b101) n_on++;
      else if (led_rgb[2:0] !== 3'b000) n_bad++;
    end
    chk("pwm40_on_cycles", 32'(n_on), 32'd64);
    chk("pwm40_bad_cycles", 32'(n_bad), 32'd0);

    wr32(16'h0214, 32'h0000_0000, 4'h1);
    repeat (3) @(negedge PCLK);
    n_on = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge PCLK);
      if (led_rgb[2:0] !== 3'b000) n_on++;
    end
    chk("pwm0_on_cycles", 32'(n_on), 32'd0);

    // Blink on channel 1: half-period 2 frames -> toggle every 3*256 cycles
    wr32(16'h021C, 32'h0002_0000, 4'h4);
    wr32(16'h0218, 32'h0000_0022, 4'h1);
    wait_ch1_change(t0, ok);
    chk("blink_t0_seen", {31'b0, ok}, 32'd1);
    chk("blink_first_on", {29'b0, led_rgb[5:3]}, 32'h2);
    wait_ch1_change(t1, ok);
    chk("blink_t1_seen", {31'b0, ok}, 32'd1);
    chk("blink_off_val", {29'b0, led_rgb[5:3]}, 32'h0);
    chk("blink_period", 32'(t1 - t0), 32'd768);
    repeat (100) @(negedge PCLK);
    wr32(16'h0218, 32'h0000_0022, 4'h1);
    wait_ch1_change(t2, ok);
    chk("blink_t2_seen", {31'b0, ok}, 32'd1);
    chk("blink_same_mode_period", 32'(t2 - t1), 32'd768);
    chk("blink_on_again", {29'b0, led_rgb[5:3]}, 32'h2);

    // Reset asserted mid write access phase while outputs are lit
    wr32(16'h0214, 32'h0000_00FF, 4'h1);
    wr32(16'h0218, 32'h0000_0017, 4'h1);
    repeat (3) @(negedge PCLK);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h0204;
    PWDATA = 32'h0000_0055; PSTRB = 4'hF;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    chk("pre_rst_static_ch1", {29'b0, led_rgb[5:3]}, 32'h7);
    #1;
    PRESETn = 1'b0;
    #1;
    chk("async_rst_led", 32'(led_rgb), 32'd0);
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    @(negedge PCLK);
    chk("rst_idle_prdata", PRDATA, 32'd0);
    chk("rst_idle_pslverr", {31'b0, PSLVERR}, 32'd0);
    PRESETn = 1'b1;
    rd_chk("post_rst_presc", 16'h0204, 32'h0);
    rd_chk("post_rst_cfg0", 16'h0214, 32'h0);
    rd_chk("post_rst_ctrl1", 16'h0218, 32'h0);
    repeat (5) @(negedge PCLK);
    chk("post_rst_led", 32'(led_rgb), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
